// File: rtl/track_merge_arbiter.sv
// Merges per-channel formatted track streams into one output FIFO: whole packets
// are granted round-robin, and per-channel end-of-event words are coalesced into one.
module track_merge_arbiter #(
    parameter int unsigned N_IN        = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TRACK_WORDS = 7,
    parameter int unsigned TAG_W       = 8
) (
    input  logic                     CLOCK,
    input  logic                     RESET_N,
    input  logic [N_IN-1:0]          ENABLE,
    input  logic [N_IN*DATA_W-1:0]   IN_DATA,
    input  logic [N_IN-1:0]          IN_EP,
    input  logic [N_IN-1:0]          IN_EE,
    input  logic [N_IN-1:0]          IN_EMPTY,
    output logic [N_IN-1:0]          IN_RE,
    output logic [DATA_W-1:0]        OUT_DATA,
    output logic                     OUT_WE,
    output logic                     OUT_EP,
    output logic                     OUT_EE,
    input  logic                     OUT_FULL,
    output logic [N_IN-1:0]          GRANT,
    output logic                     ERR_TAG,
    output logic                     ERR_LEN
);

    localparam int unsigned PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned CNT_W = $clog2(TRACK_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_EE_EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [N_IN-1:0]     ee_seen_q, ee_seen_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_IN-1:0]     grant_q, grant_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_we_q, out_we_d;
    logic                out_ep_q, out_ep_d;
    logic                out_ee_q, out_ee_d;
    logic                err_tag_q, err_tag_d;
    logic                err_len_q, err_len_d;

    logic [N_IN-1:0]     re_c;
    logic [N_IN-1:0]     cand;
    logic                all_ee;
    logic                found;
    logic [PTR_W-1:0]    win;
    logic [PTR_W-1:0]    sel;
    logic [DATA_W-1:0]   sel_data;
    logic [CNT_W-1:0]    cnt_nxt;
    int unsigned         idx;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gidx_d     = gidx_q;
        ee_seen_d  = ee_seen_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        out_data_d = out_data_q;
        out_we_d   = 1'b0;
        out_ep_d   = 1'b0;
        out_ee_d   = 1'b0;
        err_tag_d  = err_tag_q;
        err_len_d  = err_len_q;
        re_c       = '0;
        found      = 1'b0;
        win        = '0;
        idx        = 0;
        cnt_nxt    = cnt_q + CNT_W'(1);

        cand   = ~IN_EMPTY & ENABLE & ~ee_seen_q;
        all_ee = (ENABLE != '0) && (&(ee_seen_q | ~ENABLE));

        // First eligible channel at or after the round-robin pointer
        for (int unsigned i = 0; i < N_IN; i++) begin
            idx = (32'(rr_q) + i) % N_IN;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end

        sel      = (state_q == S_XFER) ? gidx_q : win;
        sel_data = IN_DATA[32'(sel)*DATA_W +: DATA_W];

        case (state_q)
            S_IDLE: begin
                if (all_ee) begin
                    state_d = S_EE_EMIT;
                end else if (found) begin
                    rr_d = PTR_W'((32'(win) + 32'd1) % N_IN);
                    if (IN_EE[win]) begin
                        re_c[win]      = 1'b1;
                        ee_seen_d[win] = 1'b1;
                        if (ee_seen_q == '0) begin
                            tag_d = sel_data[TAG_W-1:0];
                        end else if (sel_data[TAG_W-1:0] != tag_q) begin
                            err_tag_d = 1'b1;
                        end
                    end else begin
                        grant_d      = '0;
                        grant_d[win] = 1'b1;
                        gidx_d       = win;
                        cnt_d        = '0;
                        state_d      = S_XFER;
                    end
                end
            end

            S_XFER: begin
                if (!IN_EMPTY[gidx_q]) begin
                    // An EE at the head means the packet was cut short; close it unpopped
                    if (IN_EE[gidx_q]) begin
                        err_len_d = 1'b1;
                        grant_d   = '0;
                        state_d   = S_IDLE;
                    end else if (!OUT_FULL) begin
                        re_c[gidx_q] = 1'b1;
                        cnt_d        = cnt_nxt;
                        out_we_d     = 1'b1;
                        out_data_d   = sel_data;
                        out_ep_d     = IN_EP[gidx_q];
                        if (IN_EP[gidx_q]) begin
                            if (cnt_nxt != CNT_W'(TRACK_WORDS)) begin
                                err_len_d = 1'b1;
                            end
                            grant_d = '0;
                            state_d = S_IDLE;
                        end else if (cnt_nxt == CNT_W'(TRACK_WORDS)) begin
                            err_len_d = 1'b1;
                            out_ep_d  = 1'b1;
                            grant_d   = '0;
                            state_d   = S_IDLE;
                        end
                    end
                end
            end

            S_EE_EMIT: begin
                if (!OUT_FULL) begin
                    out_we_d   = 1'b1;
                    out_ep_d   = 1'b1;
                    out_ee_d   = 1'b1;
                    out_data_d = DATA_W'(tag_q);
                    ee_seen_d  = '0;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            gidx_q     <= '0;
            ee_seen_q  <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            out_data_q <= '0;
            out_we_q   <= 1'b0;
            out_ep_q   <= 1'b0;
            out_ee_q   <= 1'b0;
            err_tag_q  <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gidx_q     <= gidx_d;
            ee_seen_q  <= ee_seen_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            out_data_q <= out_data_d;
            out_we_q   <= out_we_d;
            out_ep_q   <= out_ep_d;
            out_ee_q   <= out_ee_d;
            err_tag_q  <= err_tag_d;
            err_len_q  <= err_len_d;
        end
    end

    // Pops are suppressed while reset is held so no input word is lost
    assign IN_RE    = RESET_N ? re_c : '0;
    assign OUT_DATA = out_data_q;
    assign OUT_WE   = out_we_q;
    assign OUT_EP   = out_ep_q;
    assign OUT_EE   = out_ee_q;
    assign GRANT    = grant_q;
    assign ERR_TAG  = err_tag_q;
    assign ERR_LEN  = err_len_q;

endmodule

// File: tb/tb_track_merge_arbiter.sv
// Directed bench for track_merge_arbiter: FWFT input FIFO models feed the DUT and
// the captured output stream is compared against hand-built expected sequences.
module tb_track_merge_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 7;
    localparam int WW = DW + 2;

    logic            CLOCK = 1'b0;
    logic            RESET_N;
    logic [N-1:0]    ENABLE;
    logic [N*DW-1:0] IN_DATA;
    logic [N-1:0]    IN_EP, IN_EE, IN_EMPTY, IN_RE, GRANT;
    logic [DW-1:0]   OUT_DATA;
    logic            OUT_WE, OUT_EP, OUT_EE, OUT_FULL, ERR_TAG, ERR_LEN;

    track_merge_arbiter #(.N_IN(N), .DATA_W(DW), .TRACK_WORDS(TW), .TAG_W(8)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE), .IN_DATA(IN_DATA),
        .IN_EP(IN_EP), .IN_EE(IN_EE), .IN_EMPTY(IN_EMPTY), .IN_RE(IN_RE),
        .OUT_DATA(OUT_DATA), .OUT_WE(OUT_WE), .OUT_EP(OUT_EP), .OUT_EE(OUT_EE),
        .OUT_FULL(OUT_FULL), .GRANT(GRANT), .ERR_TAG(ERR_TAG), .ERR_LEN(ERR_LEN)
    );

    always #5 CLOCK = ~CLOCK;

    // Input FIFO models: entries are {ee, ep, data}
    logic [WW-1:0] mem [N][64];
    logic [5:0]    wr_ptr [N];
    logic [5:0]    rd_ptr [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            IN_EMPTY[i] = (rd_ptr[i] == wr_ptr[i]);
            {IN_EE[i], IN_EP[i], IN_DATA[i*DW +: DW]} = mem[i][rd_ptr[i]];
        end
    end

    always @(posedge CLOCK or negedge RESET_N) begin
        for (int i = 0; i < N; i++) begin
            if (!RESET_N) rd_ptr[i] <= '0;
            else if (IN_RE[i]) rd_ptr[i] <= rd_ptr[i] + 6'd1;
        end
    end

    logic [WW-1:0] outq [$];
    logic [WW-1:0] expq [$];
    int            outcyc [$];
    int            cyc = 0;
    int            interleave = 0;

    always @(negedge CLOCK) begin
        cyc <= cyc + 1;
        if (!RESET_N) begin
            outq.delete();
            outcyc.delete();
        end else begin
            if (OUT_WE) begin
                outq.push_back({OUT_EE, OUT_EP, OUT_DATA});
                outcyc.push_back(cyc);
            end
            if (IN_RE != '0 && GRANT != '0 && IN_RE != GRANT) interleave <= interleave + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int ch, input logic ee, input logic ep, input logic [DW-1:0] d);
        mem[ch][wr_ptr[ch]] = {ee, ep, d};
        wr_ptr[ch] = wr_ptr[ch] + 6'd1;
    endtask

    task automatic push_pkt(input int ch, input logic [DW-1:0] base, input int len, input bit exp_it);
        for (int k = 0; k < len; k++) begin
            push(ch, 1'b0, (k == len - 1), base + DW'(k));
            if (exp_it) expq.push_back({1'b0, (k == len - 1), base + DW'(k)});
        end
    endtask

    task automatic push_ee(input int ch, input logic [7:0] tag);
        push(ch, 1'b1, 1'b1, DW'(tag));
    endtask

    task automatic do_reset(input logic [N-1:0] en);
        @(negedge CLOCK);
        RESET_N  = 1'b0;
        OUT_FULL = 1'b0;
        ENABLE   = en;
        for (int i = 0; i < N; i++) wr_ptr[i] = '0;
        expq.delete();
        repeat (2) @(negedge CLOCK);
        #1;
        check("reset_outputs", {OUT_DATA, OUT_WE, OUT_EP, OUT_EE, GRANT, ERR_TAG, ERR_LEN, IN_RE}, 0);
    endtask

    task automatic release_reset();
        @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (outq.size() < n && k < budget) begin
            @(negedge CLOCK);
            #1;
            k++;
        end
    endtask

    task automatic cmp_out(input string tag);
        check({tag, "_count"}, 64'(outq.size()), 64'(expq.size()));
        for (int k = 0; k < expq.size() && k < outq.size(); k++) check(tag, outq[k], expq[k]);
    endtask

    task automatic run_ee(input logic [7:0] tag3, input string tag);
        do_reset(4'b1111);
        push_ee(2, 8'h05);
        expq.push_back({1'b1, 1'b1, 32'h0000_0005});
        push_pkt(2, 32'h400, 7, 1'b1);
        release_reset();
        repeat (5) @(negedge CLOCK);
        push_ee(0, 8'h05);
        repeat (5) @(negedge CLOCK);
        push_ee(3, tag3);
        repeat (5) @(negedge CLOCK);
        #1;
        check({tag, "_held"}, 64'(outq.size()), 0);
        push_ee(1, 8'h05);
        wait_out(8, 60);
        repeat (10) @(negedge CLOCK);
        #1;
        cmp_out(tag);
        check({tag, "_err_tag"}, ERR_TAG, (tag3 != 8'h05));
    endtask

    initial begin
        RESET_N  = 1'b0;
        OUT_FULL = 1'b0;
        ENABLE   = '0;
        for (int i = 0; i < N; i++) wr_ptr[i] = '0;

        // Single channel packet then EE
        do_reset(4'b0001);
        push_pkt(0, 32'h100, 7, 1'b1);
        push_ee(0, 8'h2A);
        expq.push_back({1'b1, 1'b1, 32'h0000_002A});
        release_reset();
        wait_out(8, 60);
        repeat (10) @(negedge CLOCK);
        #1;
        cmp_out("single");
        if (outcyc.size() >= 7) check("single_consec", 64'(outcyc[6] - outcyc[0]), 6);
        check("single_errs", {ERR_TAG, ERR_LEN}, 0);

        // Two channels, two packets each, round-robin
        do_reset(4'b0011);
        push_pkt(0, 32'h200, 7, 1'b0);
        push_pkt(0, 32'h210, 7, 1'b0);
        push_pkt(1, 32'h300, 7, 1'b0);
        push_pkt(1, 32'h310, 7, 1'b0);
        for (int p = 0; p < 4; p++) begin
            logic [DW-1:0] b;
            b = (p == 0) ? 32'h200 : (p == 1) ? 32'h300 : (p == 2) ? 32'h210 : 32'h310;
            for (int k = 0; k < 7; k++) expq.push_back({1'b0, (k == 6), b + DW'(k)});
        end
        release_reset();
        wait_out(28, 120);
        #1;
        cmp_out("rr");
        check("rr_interleave", 64'(interleave), 0);

        // EE coalescing, matching and mismatching tags
        run_ee(8'h05, "ee_match");
        run_ee(8'h06, "ee_mismatch");

        // Back-pressure after the third word
        do_reset(4'b0001);
        push_pkt(0, 32'h500, 7, 1'b1);
        release_reset();
        begin
            int k = 0;
            while (rd_ptr[0] != 6'd3 && k < 40) begin
                @(negedge CLOCK);
                #1;
                k++;
            end
        end
        OUT_FULL = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("full_stall_re", IN_RE, 0);
            @(negedge CLOCK);
        end
        OUT_FULL = 1'b0;
        wait_out(7, 40);
        repeat (5) @(negedge CLOCK);
        #1;
        cmp_out("full");

        // All channels disabled: inert
        do_reset(4'b0000);
        push_pkt(0, 32'h700, 7, 1'b0);
        push_ee(1, 8'h11);
        release_reset();
        repeat (20) @(negedge CLOCK);
        #1;
        check("inert_out", 64'(outq.size()), 0);
        check("inert_pops", {rd_ptr[0], rd_ptr[1], GRANT}, 0);

        // Short packet flags a length error, next packet still flows
        do_reset(4'b0001);
        push_pkt(0, 32'h600, 5, 1'b1);
        push_pkt(0, 32'h610, 7, 1'b1);
        release_reset();
        wait_out(12, 80);
        #1;
        cmp_out("short");
        check("short_err_len", {ERR_TAG, ERR_LEN}, 2'b01);

        // Reset asserted mid-packet
        push_pkt(0, 32'h620, 7, 1'b0);
        begin
            int k = 0;
            while (outq.size() < 14 && k < 40) begin
                @(negedge CLOCK);
                #1;
                k++;
            end
        end
        check("mid_grant", GRANT, 4'b0001);
        RESET_N = 1'b0;
        #1;
        check("mid_reset", {OUT_DATA, OUT_WE, OUT_EP, OUT_EE, GRANT, ERR_TAG, ERR_LEN, IN_RE}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
